// File: rtl/message_read_cntrl.sv
// Message read controller: walks stored start/end locations slot by slot and
// streams each message's bytes from the byte buffer with sop/eop framing.
module message_read_cntrl #(
   parameter int NUM_MESSAGE = 10,
   parameter int IDX_WIDTH   = 4,
   parameter int DATA_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  msg_done_i,
   output logic                  re_o,
   output logic                  read_start_o,
   output logic                  read_end_o,
   output logic [IDX_WIDTH-1:0]  loc_addr_o,
   input  logic [DATA_WIDTH-1:0] start_i,
   input  logic [DATA_WIDTH-1:0] end_i,
   output logic                  buf_re_o,
   output logic [DATA_WIDTH-1:0] buf_addr_o,
   input  logic [7:0]            buf_data_i,
   output logic [7:0]            data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  rel_valid_o,
   output logic [DATA_WIDTH-1:0] rel_addr_o,
   output logic [IDX_WIDTH-1:0]  pending_o,
   output logic                  overflow_o
);

   typedef enum logic [2:0] {
      IDLE,
      RD_START,
      RD_END,
      CAP_END,
      STREAM,
      RELEASE
   } state_t;

   localparam logic [IDX_WIDTH-1:0] LP_FULL     = IDX_WIDTH'(NUM_MESSAGE);
   localparam logic [IDX_WIDTH-1:0] LP_LAST_IDX = IDX_WIDTH'(NUM_MESSAGE - 1);

   state_t                  r_state;
   state_t                  w_next_state;

   logic [IDX_WIDTH-1:0]    r_rd_idx;
   logic [DATA_WIDTH-1:0]   r_cur;
   logic [DATA_WIDTH-1:0]   r_last;
   logic                    r_first_flag;
   logic                    r_all_issued;
   logic                    r_inflight;
   logic                    r_inflight_eop;
   logic [IDX_WIDTH-1:0]    r_pending;
   logic                    r_overflow;
   logic [7:0]              r_data;
   logic                    r_valid;
   logic                    r_sop;
   logic                    r_eop;

   logic                    w_xfer;
   logic                    w_buf_re;
   logic                    w_release;
   logic                    w_store;
   logic                    w_at_last;

   assign w_xfer    = r_valid & ready_i;
   assign w_release = (r_state == RELEASE);
   assign w_at_last = (r_cur == r_last);

   // One read in flight at most; a held byte must leave before the next read issues.
   assign w_buf_re  = (r_state == STREAM) & ~r_inflight & ~r_all_issued &
                      (~r_valid | ready_i);

   // A full slot table still accepts a new message when one is retiring this cycle.
   assign w_store   = msg_done_i & ((r_pending != LP_FULL) | w_release);

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      w_next_state = r_state;
      re_o         = 1'b0;
      read_start_o = 1'b0;
      read_end_o   = 1'b0;
      rel_valid_o  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_pending != '0) w_next_state = RD_START;
         end
         RD_START: begin
            re_o         = 1'b1;
            read_start_o = 1'b1;
            w_next_state = RD_END;
         end
         RD_END: begin
            re_o         = 1'b1;
            read_end_o   = 1'b1;
            w_next_state = CAP_END;
         end
         CAP_END: begin
            w_next_state = STREAM;
         end
         STREAM: begin
            if (w_xfer && r_eop) w_next_state = RELEASE;
         end
         RELEASE: begin
            rel_valid_o  = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur          <= '0;
         r_last         <= '0;
         r_first_flag   <= 1'b0;
         r_all_issued   <= 1'b0;
         r_inflight     <= 1'b0;
         r_inflight_eop <= 1'b0;
      end else begin
         if (r_state == RD_END) r_cur <= start_i;
         if (r_state == CAP_END) begin
            r_last       <= end_i;
            r_first_flag <= 1'b1;
            r_all_issued <= 1'b0;
         end
         if (w_buf_re) begin
            r_cur          <= r_cur + 1'b1;
            r_inflight     <= 1'b1;
            r_inflight_eop <= w_at_last;
            if (w_at_last) r_all_issued <= 1'b1;
         end else begin
            r_inflight     <= 1'b0;
         end
         if (w_xfer && r_sop) r_first_flag <= 1'b0;
      end
   end

   // Output byte register: loads when a read returns, holds under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (r_inflight) begin
         r_data  <= buf_data_i;
         r_valid <= 1'b1;
         r_sop   <= r_first_flag;
         r_eop   <= r_inflight_eop;
      end else if (w_xfer) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_idx   <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_release) begin
            if (r_rd_idx == LP_LAST_IDX) r_rd_idx <= '0;
            else                         r_rd_idx <= r_rd_idx + 1'b1;
         end
         case ({w_store, w_release})
            2'b10:   r_pending <= r_pending + 1'b1;
            2'b01:   r_pending <= r_pending - 1'b1;
            default: r_pending <= r_pending;
         endcase
         if (msg_done_i && (r_pending == LP_FULL) && !w_release) r_overflow <= 1'b1;
      end
   end

   assign loc_addr_o = r_rd_idx;
   assign buf_re_o   = w_buf_re;
   assign buf_addr_o = r_cur;
   assign data_o     = r_data;
   assign valid_o    = r_valid;
   assign sop_o      = r_sop;
   assign eop_o      = r_eop;
   assign rel_addr_o = w_release ? DATA_WIDTH'(r_last + 1'b1) : '0;
   assign pending_o  = r_pending;
   assign overflow_o = r_overflow;

endmodule
